// File: rtl/vga_score_digits.sv
// vga_score_digits: saturating 4-digit BCD score, per-frame snapshot and
// 7-segment digit raster producing a registered 12-bit pixel.
module vga_score_digits #(
    parameter int X0    = 240,
    parameter int Y0    = 200,
    parameter int DIG_W = 32,
    parameter int DIG_H = 48,
    parameter int GAP   = 8,
    parameter int T     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        clr,
    input  logic        valid,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic [11:0] bg_color,
    input  logic [11:0] seg0,
    input  logic [11:0] seg1,
    input  logic [11:0] seg2,
    input  logic [11:0] seg3,
    input  logic [11:0] seg4,
    input  logic [11:0] seg5,
    input  logic [11:0] seg6,
    input  logic [11:0] seg7,
    input  logic [11:0] seg8,
    output logic [3:0]  num,
    output logic [15:0] score,
    output logic        full,
    output logic [11:0] pixel
);
    localparam int PITCH = DIG_W + GAP;
    localparam int MID0  = DIG_H / 2 - T / 2;
    localparam int MID1  = DIG_H / 2 + T / 2;

    logic [15:0] nxt, shown;
    logic        c, c_in, in_cell, valid_d, blank;
    logic [1:0]  c_n, n;
    logic [9:0]  c_lx, lx, ly;
    logic [3:0]  dig;
    logic        l, r, top, bot, up, mid;
    logic [11:0] seg_col;
    int          h, v, lxi, lyi;

    assign full = score == 16'h9999;

    always_comb begin
        nxt = score;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                nxt[4*i +: 4] = (score[4*i +: 4] == 4'd9) ? 4'd0 : score[4*i +: 4] + 4'd1;
                c = score[4*i +: 4] == 4'd9;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score <= 16'h0000;
            shown <= 16'h0000;
        end else begin
            score <= clr ? 16'h0000 : (inc && !full) ? nxt : score;
            if (h_cnt == 10'd0 && v_cnt == 10'd0)
                shown <= score;
        end
    end

    always_comb begin
        h = {22'd0, h_cnt};
        v = {22'd0, v_cnt};
        c_in = 1'b0;
        c_n = 2'd0;
        c_lx = 10'd0;
        for (int i = 0; i < 4; i++) begin
            if (h >= X0 + i * PITCH && h < X0 + i * PITCH + DIG_W && v >= Y0 && v < Y0 + DIG_H) begin
                c_in = 1'b1;
                c_n = 2'(i);
                c_lx = 10'(h - X0 - i * PITCH);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cell <= 1'b0;
            n <= 2'd0;
            lx <= 10'd0;
            ly <= 10'd0;
            valid_d <= 1'b0;
        end else begin
            in_cell <= c_in;
            n <= c_n;
            lx <= c_lx;
            ly <= 10'(v - Y0);
            valid_d <= valid;
        end
    end

    // n=0 is the thousands digit; a digit is blank while it and all higher digits are zero
    assign dig   = n == 2'd0 ? shown[15:12] : n == 2'd1 ? shown[11:8] : n == 2'd2 ? shown[7:4] : shown[3:0];
    assign blank = n == 2'd0 ? shown[15:12] == 4'd0 : n == 2'd1 ? shown[15:8] == 8'd0 :
                   n == 2'd2 ? shown[15:4] == 12'd0 : 1'b0;
    assign num   = (in_cell && !blank) ? dig : 4'd11;

    assign lxi = {22'd0, lx};
    assign lyi = {22'd0, ly};
    assign l   = lxi < T;
    assign r   = lxi >= DIG_W - T;
    assign top = lyi < T;
    assign bot = lyi >= DIG_H - T;
    assign up  = lyi < DIG_H / 2;
    assign mid = lyi >= MID0 && lyi < MID1;

    assign seg_col = (l && mid) ? seg7 : (r && mid) ? seg8 : mid ? seg6 : top ? seg0 : bot ? seg3 :
                     (l && up) ? seg5 : l ? seg4 : (r && up) ? seg1 : r ? seg2 : bg_color;

    // blanked cells show background even if the segment stage returns colours
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pixel <= 12'h000;
        else
            pixel <= !valid_d ? 12'h000 : (in_cell && !blank) ? seg_col : bg_color;
    end
endmodule

// File: tb/tb_vga_score_digits.sv
// tb_vga_score_digits: vector table, hand sequences and random stimulus
// checked against an arithmetic model of score, snapshot and digit raster.
module tb_vga_score_digits;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inc = 1'b0, clr = 1'b0, valid = 1'b0;
    logic [9:0]  h_cnt = 10'd0, v_cnt = 10'd0;
    logic [11:0] bg_color = 12'h000;
    logic [11:0] seg [9];
    logic [3:0]  num;
    logic [15:0] score;
    logic        full;
    logic [11:0] pixel;

    vga_score_digits dut (
        .clk(clk), .rst(rst), .inc(inc), .clr(clr), .valid(valid),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .bg_color(bg_color),
        .seg0(seg[0]), .seg1(seg[1]), .seg2(seg[2]), .seg3(seg[3]), .seg4(seg[4]),
        .seg5(seg[5]), .seg6(seg[6]), .seg7(seg[7]), .seg8(seg[8]),
        .num(num), .score(score), .full(full), .pixel(pixel)
    );

    always #5 clk = ~clk;

    // stand-in for the digit-to-segment stage: colour encodes {num, segment, 5}
    always_comb
        for (int k = 0; k < 9; k++)
            seg[k] = {num, 4'(k), 4'h5};

    int checks = 0, errors = 0;
    int m_score, m_shown, p_h, p_v, exp_pix;
    bit p_valid;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 50) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int to_bcd(input int s);
        return (s / 1000) * 4096 + (s / 100 % 10) * 256 + (s / 10 % 10) * 16 + s % 10;
    endfunction

    function automatic int cell_of(input int hh, input int vv);
        for (int k = 0; k < 4; k++)
            if (hh >= 240 + 40 * k && hh < 272 + 40 * k && vv >= 200 && vv < 248) return k;
        return -1;
    endfunction

    // leading-zero blanking: digit k is blank when the number has fewer digits than its place needs
    function automatic int digit_of(input int s, input int k);
        int place;
        place = k == 0 ? 1000 : k == 1 ? 100 : k == 2 ? 10 : 1;
        if (k < 3 && s < place) return 11;
        return (s / place) % 10;
    endfunction

    function automatic int seg_of(input int x, input int y);
        bit md;
        md = y >= 22 && y < 26;
        if (x < 4 && md) return 7;
        if (x >= 28 && md) return 8;
        if (md) return 6;
        if (y < 4) return 0;
        if (y >= 44) return 3;
        if (x < 4 && y < 24) return 5;
        if (x < 4) return 4;
        if (x >= 28 && y < 24) return 1;
        if (x >= 28) return 2;
        return -1;
    endfunction

    function automatic int exp_num(input int hh, input int vv);
        int k;
        k = cell_of(hh, vv);
        return k < 0 ? 11 : digit_of(m_shown, k);
    endfunction

    function automatic int exp_px(input int hh, input int vv, input bit vld, input int bg);
        int k, d, s;
        if (!vld) return 0;
        k = cell_of(hh, vv);
        if (k < 0) return bg;
        d = digit_of(m_shown, k);
        if (d == 11) return bg;
        s = seg_of(hh - 240 - 40 * k, vv - 200);
        return s < 0 ? bg : d * 256 + s * 16 + 5;
    endfunction

    task automatic cyc(input int hh, input int vv, input bit vld, input bit i, input bit c, input int bg);
        h_cnt = 10'(hh); v_cnt = 10'(vv); valid = vld; inc = i; clr = c; bg_color = 12'(bg);
        #1;
        chk("num", 32'(num), exp_num(p_h, p_v));
        chk("pixel", 32'(pixel), exp_pix);
        chk("score", 32'(score), to_bcd(m_score));
        chk("full", 32'(full), m_score == 9999 ? 1 : 0);
        exp_pix = exp_px(p_h, p_v, p_valid, bg);
        if (hh == 0 && vv == 0) m_shown = m_score;
        if (c) m_score = 0;
        else if (i && m_score < 9999) m_score++;
        p_h = hh; p_v = vv; p_valid = vld;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; inc = 1'b0; clr = 1'b0; valid = 1'b0; h_cnt = 10'd0; v_cnt = 10'd0;
        #2;
        chk("rst_score", 32'(score), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_pixel", 32'(pixel), 0);
        chk("rst_num", 32'(num), 11);
        @(posedge clk); #1;
        rst = 1'b0;
        m_score = 0; m_shown = 0; p_h = 1023; p_v = 1023; p_valid = 0; exp_pix = 0;
    endtask

    typedef struct { int h; int v; bit vld; int num; int pix; } vec_t;
    vec_t tab [16];
    localparam int BG = 12'h0c3;

    initial begin
        tab[0]  = '{360, 200, 1'b1, 4, 12'h405};
        tab[1]  = '{240, 224, 1'b1, 1, 12'h175};
        tab[2]  = '{272, 200, 1'b1, 11, BG};
        tab[3]  = '{300, 223, 1'b0, 2, 12'h000};
        tab[4]  = '{311, 247, 1'b1, 2, 12'h235};
        tab[5]  = '{320, 210, 1'b1, 3, 12'h355};
        tab[6]  = '{349, 230, 1'b1, 3, 12'h325};
        tab[7]  = '{330, 215, 1'b1, 3, BG};
        tab[8]  = '{391, 200, 1'b1, 4, 12'h405};
        tab[9]  = '{392, 200, 1'b1, 11, BG};
        tab[10] = '{240, 248, 1'b1, 11, BG};
        tab[11] = '{370, 225, 1'b1, 4, 12'h465};
        tab[12] = '{389, 222, 1'b1, 4, 12'h485};
        tab[13] = '{345, 203, 1'b1, 3, 12'h305};
        tab[14] = '{350, 210, 1'b1, 3, 12'h315};
        tab[15] = '{242, 230, 1'b1, 1, 12'h145};

        #1;
        do_reset();
        cyc(240, 200, 1, 0, 0, BG);
        chk("blank_cell0_num", 32'(num), 11);
        cyc(360, 200, 1, 0, 0, BG);
        chk("blank_cell0_pix", 32'(pixel), BG);
        chk("ones_zero_num", 32'(num), 0);
        cyc(360, 200, 1, 0, 0, BG);
        chk("ones_zero_pix", 32'(pixel), 12'h005);

        for (int i = 0; i < 9; i++) cyc(700, 500, 0, 1, 0, 0);
        chk("score_9", 32'(score), 16'h0009);
        cyc(700, 500, 0, 1, 0, 0);
        chk("score_10", 32'(score), 16'h0010);
        for (int i = 0; i < 1224; i++) cyc(700, 500, 0, 1, 0, 0);
        chk("score_1234", 32'(score), 16'h1234);
        cyc(0, 0, 0, 0, 0, BG);

        foreach (tab[i]) begin
            cyc(tab[i].h, tab[i].v, tab[i].vld, 0, 0, BG);
            chk("tab_num", 32'(num), tab[i].num);
            cyc(tab[i].h, tab[i].v, tab[i].vld, 0, 0, BG);
            chk("tab_pix", 32'(pixel), tab[i].pix);
        end

        cyc(0, 0, 0, 1, 0, BG);
        chk("snap_inc_score", 32'(score), 16'h1235);
        cyc(360, 200, 1, 0, 0, BG);
        chk("snap_inc_hidden", 32'(num), 4);
        cyc(0, 0, 0, 0, 0, BG);
        cyc(360, 200, 1, 0, 0, BG);
        chk("next_frame_shown", 32'(num), 5);

        do_reset();
        for (int i = 0; i < 42; i++) cyc(700, 500, 0, 1, 0, 0);
        chk("score_42", 32'(score), 16'h0042);
        cyc(700, 500, 0, 1, 1, 0);
        chk("clr_prio_score", 32'(score), 0);
        chk("clr_prio_full", 32'(full), 0);

        do_reset();
        for (int i = 0; i < 9999; i++) cyc(700, 500, 0, 1, 0, 0);
        chk("sat_score", 32'(score), 16'h9999);
        chk("sat_full", 32'(full), 1);
        cyc(700, 500, 0, 1, 0, 0);
        chk("sat_hold", 32'(score), 16'h9999);
        chk("sat_hold_full", 32'(full), 1);
        cyc(700, 500, 0, 0, 1, 0);
        chk("sat_clr", 32'(score), 0);
        chk("sat_clr_full", 32'(full), 0);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int hh, vv;
            hh = $urandom_range(400, 230);
            vv = $urandom_range(260, 190);
            if ($urandom_range(49, 0) == 0) begin hh = 0; vv = 0; end
            cyc(hh, vv, $urandom_range(3, 0) != 0, 1'($urandom_range(1, 0)),
                $urandom_range(199, 0) == 0, $urandom_range(4095, 0));
        end

        cyc(330, 215, 1, 0, 0, BG);
        do_reset();
        cyc(360, 200, 1, 0, 0, BG);
        chk("post_rst_pix", 32'(pixel), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
